// File: rtl/ui_pkg.sv
// Shared types and constants for the UI event tracker: FSM states and cause bit positions.
package ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    localparam int CAUSE_W    = 4;
    localparam int CAUSE_SW   = 0;
    localparam int CAUSE_POT  = 1;
    localparam int CAUSE_SD   = 2;
    localparam int CAUSE_INIT = 3;

endpackage

// File: rtl/ui_debounce.sv
// Two-flop synchroniser plus stability-window debounce for a switch vector.
// chg_o pulses for one cycle in the same cycle q_o takes its new value.
module ui_debounce #(
    parameter int WIDTH  = 16,
    parameter int CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             chg_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, prev_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             chg_q, chg_d;

    // cnt counts consecutive cycles the synchronised value has held a
    // single value different from the committed one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_d    = 1'b0;
        prev_d   = sync2_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (sync2_q != prev_q) begin
            cnt_d = CW'(1);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CW'(CYCLES)) begin
            stable_d = sync2_q;
            chg_d    = 1'b1;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= d_i;
            sync2_q  <= sync1_q;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
        end
    end

    assign q_o   = stable_q;
    assign chg_o = chg_q;

endmodule

// File: rtl/ui_event_tracker.sv
// Collects switch/pot/SD/init events into a pending mask and publishes
// wave parameter updates through a valid/ready handshake with a cooldown.
module ui_event_tracker
    import ui_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int POT_WIDTH       = 12,
    parameter int WS_WIDTH        = 30,
    parameter int WW_WIDTH        = 18,
    parameter int WS_SHIFT        = 18,
    parameter int WW_SHIFT        = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int POT_HYST        = 8,
    parameter int COOLDOWN_CYCLES = 100
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic [POT_WIDTH-1:0] pot_in,
    input  logic                 sd_cd_in,
    input  logic                 update_ready_in,
    output logic                 update_valid_out,
    output logic [WS_WIDTH-1:0]  wave_start_out,
    output logic [WW_WIDTH-1:0]  wave_width_out,
    output logic [3:0]           cause_out
);

    localparam int CDW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int WSX = POT_WIDTH + WS_SHIFT + WS_WIDTH;
    localparam int WWX = SW_WIDTH + WW_SHIFT + WW_WIDTH;
    localparam logic [POT_WIDTH:0] HYST_V = (POT_WIDTH + 1)'(POT_HYST);
    localparam logic [CAUSE_W-1:0] POT_MASK = CAUSE_W'(1) << CAUSE_POT;

    state_e                state_q, state_d;
    logic [CDW-1:0]        cd_q, cd_d;
    logic                  valid_q, valid_d;
    logic [WS_WIDTH-1:0]   ws_q, ws_d;
    logic [WW_WIDTH-1:0]   ww_q, ww_d;
    logic [CAUSE_W-1:0]    cause_q, cause_d;
    logic [CAUSE_W-1:0]    pend_q, pend_d;
    logic [POT_WIDTH-1:0]  pot_q, pot_d;
    logic                  sd_sync1_q, sd_sync2_q, sd_prev_q;

    logic [SW_WIDTH-1:0]   sw_cmt;
    logic                  sw_chg;
    logic [POT_WIDTH:0]    pot_diff;
    logic                  pot_evt;
    logic                  sd_rise;
    logic [CAUSE_W-1:0]    evt;
    logic [WS_WIDTH-1:0]   ws_cap;
    logic [WW_WIDTH-1:0]   ww_cap;

    ui_debounce #(
        .WIDTH  (SW_WIDTH),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .d_i     (sw_in),
        .q_o     (sw_cmt),
        .chg_o   (sw_chg)
    );

    always_comb begin
        if (pot_in >= pot_q) pot_diff = {1'b0, pot_in} - {1'b0, pot_q};
        else                 pot_diff = {1'b0, pot_q} - {1'b0, pot_in};
    end

    assign pot_evt = (pot_diff > HYST_V);
    assign sd_rise = sd_sync2_q & ~sd_prev_q;

    always_comb begin
        evt             = '0;
        evt[CAUSE_SW]   = sw_chg;
        evt[CAUSE_POT]  = pot_evt;
        evt[CAUSE_SD]   = sd_rise;
    end

    // The pot sample captured becomes the new reference, so the capture-cycle
    // pot event is already satisfied by this update.
    assign ws_cap = WS_WIDTH'(WSX'(pot_in) << WS_SHIFT);
    assign ww_cap = WW_WIDTH'(WWX'(sw_cmt) << WW_SHIFT);

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        valid_d = valid_q;
        ws_d    = ws_q;
        ww_d    = ww_q;
        cause_d = cause_q;
        pot_d   = pot_q;
        pend_d  = pend_q | evt;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    ws_d    = ws_cap;
                    ww_d    = ww_cap;
                    cause_d = pend_q;
                    pot_d   = pot_in;
                    pend_d  = evt & ~POT_MASK;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (valid_q && update_ready_in) begin
                    valid_d = 1'b0;
                    cd_d    = '0;
                    state_d = (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (cd_q == CDW'(COOLDOWN_CYCLES - 1)) state_d = ST_IDLE;
                else                                  cd_d    = cd_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            cd_q       <= '0;
            valid_q    <= 1'b0;
            ws_q       <= '0;
            ww_q       <= '0;
            cause_q    <= '0;
            pend_q     <= CAUSE_W'(1) << CAUSE_INIT;
            pot_q      <= '0;
            sd_sync1_q <= 1'b0;
            sd_sync2_q <= 1'b0;
            sd_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            valid_q    <= valid_d;
            ws_q       <= ws_d;
            ww_q       <= ww_d;
            cause_q    <= cause_d;
            pend_q     <= pend_d;
            pot_q      <= pot_d;
            sd_sync1_q <= sd_cd_in;
            sd_sync2_q <= sd_sync1_q;
            sd_prev_q  <= sd_sync2_q;
        end
    end

    assign update_valid_out = valid_q;
    assign wave_start_out   = ws_q;
    assign wave_width_out   = ww_q;
    assign cause_out        = cause_q;

endmodule

// File: tb/tb_ui_event_tracker.sv
// Scoreboard bench for ui_event_tracker: expected updates are queued as
// stimulus is driven and checked on each handshake or stall cycle.
module tb_ui_event_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic [11:0] pot;
    logic        sd;
    logic        ready;
    logic        valid;
    logic [29:0] ws;
    logic [17:0] ww;
    logic [3:0]  cause;

    typedef struct {
        logic [3:0]  cause;
        logic [17:0] ww;
        logic [29:0] ws;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ui_event_tracker #(
        .SW_WIDTH        (16),
        .POT_WIDTH       (12),
        .WS_WIDTH        (30),
        .WW_WIDTH        (18),
        .WS_SHIFT        (18),
        .WW_SHIFT        (2),
        .DEBOUNCE_CYCLES (4),
        .POT_HYST        (8),
        .COOLDOWN_CYCLES (8)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .sw_in            (sw),
        .pot_in           (pot),
        .sd_cd_in         (sd),
        .update_ready_in  (ready),
        .update_valid_out (valid),
        .wave_start_out   (ws),
        .wave_width_out   (ww),
        .cause_out        (cause)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [15:0] s, input logic [11:0] p);
        exp_t e;
        e.cause = c;
        e.ww    = {s, 2'b00};
        e.ws    = {p, 18'd0};
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transfers pop the scoreboard; stalled cycles must show the head entry.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("xfer_cause", 32'(cause), 32'(e.cause));
                    chk("xfer_width", 32'(ww), 32'(e.ww));
                    chk("xfer_start", 32'(ws), 32'(e.ws));
                end
            end else if (sb.size() > 0) begin
                chk("hold_cause", 32'(cause), 32'(sb[0].cause));
                chk("hold_width", 32'(ww), 32'(sb[0].ww));
                chk("hold_start", 32'(ws), 32'(sb[0].ws));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ready = 1'b1;
        sw    = '0;
        pot   = '0;
        sd    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_start", 32'(ws), 32'd0);
        chk("rst_width", 32'(ww), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);

        // INIT update one cycle after release
        push(4'b1000, 16'd0, 12'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("init_lat", 32'(valid), 32'd1);
        step(16);

        // pot thresholds
        pot = 12'd100;
        push(4'b0010, 16'd0, 12'd100);
        step(16);
        pot = 12'd105;
        step(16);
        pot = 12'd109;
        push(4'b0010, 16'd0, 12'd109);
        step(16);

        // 3-cycle switch glitch must not commit, then a stable change does
        sw = 16'h0003;
        step(3);
        sw = 16'h0000;
        step(16);
        sw = 16'h0003;
        push(4'b0001, 16'h0003, 12'd109);
        step(20);

        // stall with SD rising during HOLD
        ready = 1'b0;
        pot   = 12'd200;
        push(4'b0010, 16'h0003, 12'd200);
        step(4);
        chk("stall_valid", 32'(valid), 32'd1);
        sd = 1'b1;
        push(4'b0100, 16'h0003, 12'd200);
        step(20);
        chk("stall_valid_end", 32'(valid), 32'd1);
        ready = 1'b1;
        step(30);
        sd = 1'b0;
        step(4);

        // SW and POT accumulate during HOLD into a single update
        ready = 1'b0;
        pot   = 12'd300;
        push(4'b0010, 16'h0003, 12'd300);
        step(4);
        sw  = 16'h0007;
        pot = 12'd400;
        step(12);
        push(4'b0011, 16'h0007, 12'd400);
        ready = 1'b1;
        step(30);

        // reset mid-HOLD aborts the held update
        ready = 1'b0;
        pot   = 12'd500;
        push(4'b0010, 16'h0007, 12'd500);
        step(6);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(valid), 32'd0);
        chk("rst_async_cause", 32'(cause), 32'd0);
        sb.delete();
        step(2);
        push(4'b1000, 16'h0000, 12'd500);
        push(4'b0001, 16'h0007, 12'd500);
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("init2_lat", 32'(valid), 32'd1);
        step(40);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
